// File: rtl/frame_pkg.sv
// rtl/frame_pkg.sv - shared types and constants for the frame scheduler
package frame_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      RUN
   } state_t;

   localparam int FIX_W  = 32;
   localparam int FRAC_W = 28;

   localparam logic [FIX_W-1:0] DEF_RE_MIN = 32'hE000_0000;
   localparam logic [FIX_W-1:0] DEF_IM_MAX = 32'h1800_0000;
   localparam logic [FIX_W-1:0] DEF_STEP   = 32'h0006_0000;

   // Raster limits for a given line/frame size, as 16-bit two's complement.
   function automatic logic [15:0] x_min(input int x_size);
      return 16'(-(x_size / 2));
   endfunction

   function automatic logic [15:0] x_max(input int x_size);
      return 16'(x_size / 2 - 1);
   endfunction

   function automatic logic [15:0] y_min(input int y_size);
      return 16'(1 - y_size / 2);
   endfunction

   function automatic logic [15:0] y_max(input int y_size);
      return 16'(y_size / 2);
   endfunction

endpackage

// File: rtl/frame_scheduler_raster_counter.sv
// rtl/frame_scheduler_raster_counter.sv - raster x/y position counter with line and frame wrap
module raster_counter
   import frame_pkg::*;
#(
   parameter int X_SIZE = 2048,
   parameter int Y_SIZE = 2048
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        load,
   input  logic        advance,
   output logic [15:0] x,
   output logic [15:0] y,
   output logic        at_eol,
   output logic        at_last
);

   localparam logic [15:0] X_MIN = x_min(X_SIZE);
   localparam logic [15:0] X_MAX = x_max(X_SIZE);
   localparam logic [15:0] Y_MIN = y_min(Y_SIZE);
   localparam logic [15:0] Y_MAX = y_max(Y_SIZE);

   assign at_eol  = (x == X_MAX);
   assign at_last = at_eol && (y == Y_MIN);

   // x scans left to right, y scans top (positive) to bottom.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         x <= '0;
         y <= '0;
      end else if (load) begin
         x <= X_MIN;
         y <= Y_MAX;
      end else if (advance) begin
         if (at_eol) begin
            x <= X_MIN;
            y <= y - 16'd1;
         end else begin
            x <= x + 16'd1;
         end
      end
   end

endmodule

// File: rtl/frame_scheduler.sv
// rtl/frame_scheduler.sv - sequences one raster frame of pixel coordinates onto a valid/ready stream
module frame_scheduler
   import frame_pkg::*;
#(
   parameter int               X_SIZE     = 2048,
   parameter int               Y_SIZE     = 2048,
   parameter int               FIX_W      = 32,
   parameter logic [FIX_W-1:0] DEF_RE_MIN = frame_pkg::DEF_RE_MIN,
   parameter logic [FIX_W-1:0] DEF_IM_MAX = frame_pkg::DEF_IM_MAX,
   parameter logic [FIX_W-1:0] DEF_STEP   = frame_pkg::DEF_STEP
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start,
   input  logic             stop,
   input  logic             continuous,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [FIX_W-1:0] cfg_re_min,
   input  logic [FIX_W-1:0] cfg_im_max,
   input  logic [FIX_W-1:0] cfg_step,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [15:0]      m_x,
   output logic [15:0]      m_y,
   output logic [FIX_W-1:0] m_re,
   output logic [FIX_W-1:0] m_im,
   output logic             m_sof,
   output logic             m_eol,
   output logic             busy,
   output logic             frame_done,
   output logic [15:0]      frame_count
);

   state_t state, state_next;

   logic [15:0]      x, y;
   logic             at_eol, at_last;
   logic             fire, last_fire, load, advance;
   logic             pending, stop_latched, cont_latched;
   logic [FIX_W-1:0] act_re_min, act_im_max, act_step;
   logic [FIX_W-1:0] sh_re_min, sh_im_max, sh_step;

   assign fire      = m_valid && m_ready;
   assign last_fire = (state == RUN) && fire && at_last;
   assign load      = (state == LOAD);
   assign advance   = (state == RUN) && fire && !at_last;

   assign busy      = (state != IDLE);
   assign cfg_ready = !pending;
   assign m_x       = x;
   assign m_y       = y;
   assign m_eol     = m_valid && at_eol;

   raster_counter #(
      .X_SIZE (X_SIZE),
      .Y_SIZE (Y_SIZE)
   ) u_raster (
      .clk     (clk),
      .resetn  (resetn),
      .load    (load),
      .advance (advance),
      .x       (x),
      .y       (y),
      .at_eol  (at_eol),
      .at_last (at_last)
   );

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE: begin
            if (start) state_next = LOAD;
         end
         LOAD: begin
            state_next = RUN;
         end
         RUN: begin
            if (last_fire) state_next = (cont_latched && !stop_latched) ? LOAD : IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         m_valid      <= 1'b0;
         m_sof        <= 1'b0;
         m_re         <= '0;
         m_im         <= '0;
         frame_done   <= 1'b0;
         frame_count  <= '0;
         pending      <= 1'b0;
         stop_latched <= 1'b0;
         cont_latched <= 1'b0;
         act_re_min   <= DEF_RE_MIN;
         act_im_max   <= DEF_IM_MAX;
         act_step     <= DEF_STEP;
         sh_re_min    <= '0;
         sh_im_max    <= '0;
         sh_step      <= '0;
      end else begin
         frame_done <= last_fire;
         if (last_fire) frame_count <= frame_count + 16'd1;

         if (state == IDLE && start) cont_latched <= continuous;

         if (state == RUN && state_next == IDLE) begin
            stop_latched <= 1'b0;
         end else if (state != IDLE && stop) begin
            stop_latched <= 1'b1;
         end

         // Shadow is only promoted at LOAD, so a cfg accepted during LOAD waits a frame.
         if (load && pending) begin
            act_re_min <= sh_re_min;
            act_im_max <= sh_im_max;
            act_step   <= sh_step;
            pending    <= 1'b0;
         end else if (cfg_valid && !pending) begin
            sh_re_min <= cfg_re_min;
            sh_im_max <= cfg_im_max;
            sh_step   <= cfg_step;
            pending   <= 1'b1;
         end

         if (load) begin
            m_valid <= 1'b1;
            m_sof   <= 1'b1;
            m_re    <= pending ? sh_re_min : act_re_min;
            m_im    <= pending ? sh_im_max : act_im_max;
         end else if (state == RUN && fire) begin
            m_sof <= 1'b0;
            if (at_last) begin
               m_valid <= 1'b0;
            end else if (at_eol) begin
               m_re <= act_re_min;
               m_im <= m_im - act_step;
            end else begin
               m_re <= m_re + act_step;
            end
         end
      end
   end

endmodule

// File: doc/frame_scheduler.md
Name: frame_scheduler

Overview:
- Sequences one raster frame of pixel coordinates into the per-pixel compute pipeline.
- Holds the viewport configuration: top-left complex coordinate and per-pixel step.
- Converts integer raster positions to fixed-point re/im using incremental accumulation (no multipliers).
- Emits a valid/ready stream with start-of-frame and end-of-line flags; supports single-shot or continuous frames, with configuration updates applied only at frame boundaries.

Parameters:
- X_SIZE, 2048, pixels per line (even, >=2).
- Y_SIZE, 2048, lines per frame (even, >=2).
- FIX_W, 32, width of re/im/step, signed Q4.28.
- DEF_RE_MIN, 32'hE0000000, reset value of active re_min (-2.0).
- DEF_IM_MAX, 32'h18000000, reset value of active im_max (+1.5).
- DEF_STEP, 32'h00060000, reset value of active step (~3/2048).

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- start  in  1  begin frame(s); sampled only in IDLE
- stop  in  1  request halt after current frame; sticky until IDLE
- continuous  in  1  sampled at start: 1 = loop frames until stop
- cfg_valid  in  1  new viewport offered
- cfg_ready  out  1  = !pending; cfg accepted when cfg_valid && cfg_ready
- cfg_re_min  in  FIX_W  left-edge real value
- cfg_im_max  in  FIX_W  top-edge imaginary value
- cfg_step  in  FIX_W  per-pixel increment (both axes)
- m_valid  out  1  output beat valid
- m_ready  in  1  downstream accepts
- m_x  out  16  signed raster x, -X_SIZE/2 .. X_SIZE/2-1
- m_y  out  16  signed raster y, Y_SIZE/2 .. 1-Y_SIZE/2
- m_re  out  FIX_W  real coordinate
- m_im  out  FIX_W  imaginary coordinate
- m_sof  out  1  first beat of frame (x=-X_SIZE/2, y=Y_SIZE/2)
- m_eol  out  1  last beat of a line (x=X_SIZE/2-1)
- busy  out  1  state != IDLE
- frame_done  out  1  one-cycle pulse after last beat of a frame handshakes
- frame_count  out  16  completed frames, wraps at 2^16

Behaviour:
- Reset:
  - state=IDLE; all m_* = 0; busy=0; frame_done=0; frame_count=0; pending=0; stop latch=0.
  - Active config = DEF_*; shadow config cleared.
- States: IDLE, LOAD, RUN.
  - IDLE -> LOAD when start=1.
  - LOAD (1 cycle): if pending, copy shadow -> active and clear pending. Set x=-X_SIZE/2, y=Y_SIZE/2, re=re_min, im=im_max. Assert m_valid and m_sof.
  - RUN: advance on a handshake (m_valid && m_ready).
- Latency: start sampled at edge N -> LOAD after N -> m_valid=1 after edge N+1.
- Output hold: while m_valid && !m_ready, every m_* holds stable.
- Advance on handshake:
  - Not at line end: x+1, re += step.
  - At line end (x=X_SIZE/2-1): x=-X_SIZE/2, re=re_min, y-1, im -= step.
- m_eol is combinational from x. m_sof is high only for the LOAD-launched beat.
- Last beat is x=X_SIZE/2-1, y=1-Y_SIZE/2. On its handshake:
  - frame_done pulses the next cycle; frame_count increments.
  - If continuous && !stop_latched: go to LOAD (m_valid low for exactly 1 cycle).
  - Otherwise: go to IDLE, m_valid=0, stop latch cleared.
- stop: latched whenever busy. Never truncates a frame. stop in IDLE is ignored.
- Arithmetic: re/im are two's complement with FIX_W-bit wrap; no saturation. The step accumulation error is exactly zero (pure adds).
- Config:
  - A cfg handshake loads the shadow and sets pending; cfg_ready=0 while pending.
  - A cfg handshake in the same cycle as LOAD is not used for that frame; it applies at the next LOAD.
  - A second cfg while pending is back-pressured, never dropped.
- start while busy: ignored.
- continuous: sampled only at start.
- Reset mid-frame: immediately returns to reset values. No frame_done; the partial frame is discarded.

Decomposition:
- Package frame_pkg:
  - state enum {IDLE, LOAD, RUN}
  - FIX_W / Q4.28 fraction width constant
  - DEF_* viewport constants
  - helper localparams X_MIN, X_MAX, Y_MIN, Y_MAX derived from sizes
- Sub-module raster_counter:
  - Inputs: clk, resetn, load, advance.
  - Outputs: x, y, at_eol, at_last.
  - Owns the x/y wrap logic.
- frame_scheduler owns the FSM, config shadow, re/im accumulators and the output register.

Test Plan:
- Geometry, X_SIZE=4, Y_SIZE=4, m_ready=1, defaults, start pulse:
  - m_valid rises 2 cycles after start; 16 beats, x order -2,-1,0,1 per line, y order 2,1,0,-1.
  - m_sof only on beat 0; m_eol on beats 3,7,11,15.
  - frame_done pulses once; frame_count=1; returns to IDLE.
- Arithmetic, cfg re_min=0, im_max=0, step=0x10000000 (1.0):
  - Beat 5 (x=-1, y=1) has re=1.0, im=-1.0.
  - Last beat has re=3.0, im=-3.0.
- Backpressure, m_ready low for 3 cycles mid-line at beat 6:
  - All m_* stable across those cycles.
  - Beat 6 accepted exactly once; beat 7 follows.
- Config timing, cfg handshake mid-frame 1 (re_min=0x10000000) in continuous mode:
  - cfg_ready=0 until LOAD.
  - Frame 1 uses the old re_min; frame 2 beat 0 re=0x10000000.
  - Exactly 1 bubble cycle between the frames.
- Continuous + stop asserted at frame 2 beat 3:
  - Frame 2 completes all 16 beats; frame_count=2; IDLE.
  - start while busy is ignored.
- resetn low at beat 9:
  - Next cycle m_valid=0, frame_count=0, active config = defaults, no frame_done.
  - New start yields m_sof with x=-2, y=2.
